// File: rtl/arbiter_rr_pe.sv
// arbiter_rr_pe: round-robin arbiter that shares one resource among CLIENTS
// requesters. The winner is found with a trailing-one priority encoder. The
// encoder looks first at the requests above the last-granted index and falls
// back to the whole candidate vector when there are none, which wraps the
// rotation. The grant is registered and held until the owner releases it.
//
// Optional feature macro: ARB_GNT_TIMEOUT_EN. When it is defined, a grant that
// is still unacknowledged after TIMEOUT cycles is revoked, and timeout_pulse
// goes high for one cycle.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   block_arb      suppresses new grants; an active grant is unaffected
//   request        per-client request level
//   grant_ack      per-client acknowledge (only the owner's bit matters)
//   grant_valid    a grant is active
//   grant          one-hot grant, zero while idle
//   grant_id       index of the current/most recent owner
//   last_grant     one-hot of the most recently granted client
//   timeout_pulse  (ARB_GNT_TIMEOUT_EN only) one-cycle revoke indication
//
// Handshake: a client holds request high until it is done. The owner k
// releases the resource at any edge where grant_ack[k]=1 or request[k]=0; both
// together count as a single release. On release the grant may move straight
// to the next winner at the same edge.
module arbiter_rr_pe #(
  parameter int CLIENTS = 8,
  parameter int TIMEOUT = 16,
  parameter int ID_W    = $clog2(CLIENTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               block_arb,
  input  logic [CLIENTS-1:0] request,
  input  logic [CLIENTS-1:0] grant_ack,
  output logic               grant_valid,
  output logic [CLIENTS-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic [CLIENTS-1:0] last_grant
`ifdef ARB_GNT_TIMEOUT_EN
  ,
  output logic               timeout_pulse
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [ID_W-1:0]    grant_id_nxt;
  logic [CLIENTS-1:0] grant_nxt, last_grant_nxt;
  logic [CLIENTS-1:0] cand, mask, masked;
  logic [ID_W-1:0]    win_id;
  logic [CLIENTS-1:0] win_onehot;
  logic               win_found;
  logic               owner_ack, owner_req;
  logic               release_now, revoke, issue;

  function automatic logic [ID_W-1:0] trailing_one(input logic [CLIENTS-1:0] v);
    trailing_one = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (v[i]) trailing_one = ID_W'(i);
    end
  endfunction

  // The grant register is zero while idle, so clearing it from the requests
  // removes the current owner only while a grant is held.
  assign cand = request & ~grant;

  always_comb begin
    mask = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (i > int'(ptr)) mask[i] = 1'b1;
    end
  end

  assign masked     = cand & mask;
  assign win_found  = |cand;
  assign win_id     = (|masked) ? trailing_one(masked) : trailing_one(cand);
  assign win_onehot = CLIENTS'(1) << win_id;

  assign owner_ack   = |(grant_ack & grant);
  assign owner_req   = |(request & grant);
  assign release_now = (state == GRANT) && (owner_ack || !owner_req);

`ifdef ARB_GNT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] age;
  logic             timeout_hit;

  // age counts completed grant cycles. At TIMEOUT-1 the current cycle is the
  // TIMEOUT-th one, so the grant is revoked at its closing edge.
  assign timeout_hit = (state == GRANT) && !release_now && (age == CNT_W'(TIMEOUT - 1));
  assign revoke      = release_now || timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age           <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      if (issue) begin
        age <= '0;
      end else if ((state == GRANT) && !release_now) begin
        age <= age + 1'b1;
      end
    end
  end
`else
  assign revoke = release_now;
`endif

  assign issue = !block_arb && win_found && ((state == IDLE) || revoke);

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    grant_nxt      = grant;
    grant_id_nxt   = grant_id;
    last_grant_nxt = last_grant;
    if (issue) begin
      state_nxt      = GRANT;
      ptr_nxt        = win_id;
      grant_nxt      = win_onehot;
      grant_id_nxt   = win_id;
      last_grant_nxt = win_onehot;
    end else if ((state == GRANT) && revoke) begin
      state_nxt = IDLE;
      grant_nxt = '0;
    end
  end

  // The pointer resets to CLIENTS-1, which leaves the mask empty, so the
  // first arbitration picks the lowest requesting index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= ID_W'(CLIENTS - 1);
      grant      <= '0;
      grant_id   <= '0;
      last_grant <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      grant      <= grant_nxt;
      grant_id   <= grant_id_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign grant_valid = (state == GRANT);

endmodule

// File: tb/tb_arbiter_rr_pe.sv
// Testbench for arbiter_rr_pe (CLIENTS=8, TIMEOUT=4). It runs a vector table,
// then hand sequences for hold/timeout and mid-grant reset, then random
// traffic checked against a circular-search reference model.
module tb_arbiter_rr_pe;

  localparam int N       = 8;
  localparam int TIMEOUT = 4;

  logic         clk;
  logic         rst_n;
  logic         block_arb;
  logic [N-1:0] request;
  logic [N-1:0] grant_ack;
  logic         grant_valid;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic [N-1:0] last_grant;
`ifdef ARB_GNT_TIMEOUT_EN
  logic         timeout_pulse;
`endif

  arbiter_rr_pe #(.CLIENTS(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .block_arb   (block_arb),
    .request     (request),
    .grant_ack   (grant_ack),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_id    (grant_id),
    .last_grant  (last_grant)
`ifdef ARB_GNT_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // The winner is found by walking the clients circularly from the slot after
  // the last grant, taking the first candidate that is requesting.
  bit m_valid;
  int m_owner, m_ptr, m_id, m_last, m_age;
  bit m_pulse;

  function automatic void m_reset();
    m_valid = 0; m_owner = 0; m_ptr = N - 1; m_id = 0; m_last = -1;
    m_age = 0; m_pulse = 0;
  endfunction

  function automatic int m_pick(logic [N-1:0] c);
    for (int j = 1; j <= N; j++) begin
      int idx;
      idx = (m_ptr + j) % N;
      if (c[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void m_issue(int w);
    m_valid = 1; m_owner = w; m_ptr = w; m_id = w; m_last = w; m_age = 0;
  endfunction

  function automatic void m_step(logic [N-1:0] r, logic [N-1:0] a, logic b);
    logic [N-1:0] c;
    int w;
    bit rel, to;
    m_pulse = 0;
    if (m_valid) begin
      rel = a[m_owner] || !r[m_owner];
      to  = 0;
`ifdef ARB_GNT_TIMEOUT_EN
      to = !rel && (m_age == TIMEOUT - 1);
`endif
      if (rel || to) begin
        c = r;
        c[m_owner] = 1'b0;
        w = m_pick(c);
        if (!b && w >= 0) m_issue(w);
        else m_valid = 0;
        m_pulse = to;
      end else begin
        m_age++;
      end
    end else begin
      w = m_pick(r);
      if (!b && w >= 0) m_issue(w);
    end
  endfunction

  function automatic void check_model(string tag);
    logic [N-1:0] eg, el;
    eg = m_valid ? (N'(1) << m_owner) : '0;
    el = (m_last < 0) ? '0 : (N'(1) << m_last);
    check({tag, ".valid"}, 32'(grant_valid), 32'(m_valid));
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".grant_id"}, 32'(grant_id), 32'(m_id));
    check({tag, ".last_grant"}, 32'(last_grant), 32'(el));
`ifdef ARB_GNT_TIMEOUT_EN
    check({tag, ".timeout_pulse"}, 32'(timeout_pulse), 32'(m_pulse));
`endif
  endfunction

  // ---------------- driver ----------------
  // Inputs are driven just after a rising edge; outputs are sampled 1 time
  // unit after the next rising edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] a, input logic b,
                      input string tag);
    request = r; grant_ack = a; block_arb = b;
    m_step(r, a, b);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic         blk;
    logic         e_valid;
    logic [N-1:0] e_grant;
    logic [2:0]   e_id;
    logic [N-1:0] e_last;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic [N-1:0] rq, logic [N-1:0] ak, logic bk,
                     logic ev, logic [N-1:0] eg, logic [2:0] ei, logic [N-1:0] el);
    vec_t v;
    v.req = rq; v.ack = ak; v.blk = bk;
    v.e_valid = ev; v.e_grant = eg; v.e_id = ei; v.e_last = el;
    tbl.push_back(v);
  endtask

  initial begin
    // full load: first grant after reset, then ack each cycle -> 0..7, wrap
    add(8'hFF, 8'h00, 0, 1, 8'h01, 3'd0, 8'h01);
    add(8'hFF, 8'h01, 0, 1, 8'h02, 3'd1, 8'h02);
    add(8'hFF, 8'h02, 0, 1, 8'h04, 3'd2, 8'h04);
    add(8'hFF, 8'h04, 0, 1, 8'h08, 3'd3, 8'h08);
    add(8'hFF, 8'h08, 0, 1, 8'h10, 3'd4, 8'h10);
    add(8'hFF, 8'h10, 0, 1, 8'h20, 3'd5, 8'h20);
    add(8'hFF, 8'h20, 0, 1, 8'h40, 3'd6, 8'h40);
    add(8'hFF, 8'h40, 0, 1, 8'h80, 3'd7, 8'h80);
    add(8'hFF, 8'h80, 0, 1, 8'h01, 3'd0, 8'h01);
    // sparse rotation 0,7,0,7
    add(8'h81, 8'h01, 0, 1, 8'h80, 3'd7, 8'h80);
    add(8'h81, 8'h80, 0, 1, 8'h01, 3'd0, 8'h01);
    add(8'h81, 8'h01, 0, 1, 8'h80, 3'd7, 8'h80);
    add(8'h81, 8'h80, 0, 1, 8'h01, 3'd0, 8'h01);
    // release to idle; id/last retained
    add(8'h00, 8'h01, 0, 0, 8'h00, 3'd0, 8'h01);
    // block while idle, then unblock, then block during a grant
    add(8'h10, 8'h00, 1, 0, 8'h00, 3'd0, 8'h01);
    add(8'h10, 8'h00, 1, 0, 8'h00, 3'd0, 8'h01);
    add(8'h10, 8'h00, 0, 1, 8'h10, 3'd4, 8'h10);
    add(8'h10, 8'h00, 1, 1, 8'h10, 3'd4, 8'h10);
    add(8'h10, 8'h00, 1, 1, 8'h10, 3'd4, 8'h10);
    add(8'h10, 8'h10, 1, 0, 8'h00, 3'd4, 8'h10);
    add(8'h00, 8'h00, 0, 0, 8'h00, 3'd4, 8'h10);
    // withdrawal: owner 3 drops, 5 takes over; non-owner acks ignored;
    // then 6 before 2
    add(8'h08, 8'h00, 0, 1, 8'h08, 3'd3, 8'h08);
    add(8'h20, 8'h00, 0, 1, 8'h20, 3'd5, 8'h20);
    add(8'h64, 8'h00, 0, 1, 8'h20, 3'd5, 8'h20);
    add(8'h64, 8'h44, 0, 1, 8'h20, 3'd5, 8'h20);
    add(8'h44, 8'h00, 0, 1, 8'h40, 3'd6, 8'h40);
    add(8'h44, 8'h40, 0, 1, 8'h04, 3'd2, 8'h04);
    // ack plus withdrawal in the same cycle is one release
    add(8'h00, 8'h04, 0, 0, 8'h00, 3'd2, 8'h04);
  end

  // ---------------- main test ----------------
  initial begin
    rst_n = 1'b0; block_arb = 1'b0; request = 8'hFF; grant_ack = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid", 32'(grant_valid), 32'd0);
    check("reset.grant", 32'(grant), 32'd0);
    check("reset.grant_id", 32'(grant_id), 32'd0);
    check("reset.last_grant", 32'(last_grant), 32'd0);
`ifdef ARB_GNT_TIMEOUT_EN
    check("reset.timeout_pulse", 32'(timeout_pulse), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].ack, tbl[i].blk, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.exp_valid", i), 32'(grant_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d.exp_grant", i), 32'(grant), 32'(tbl[i].e_grant));
      check($sformatf("tbl%0d.exp_id", i), 32'(grant_id), 32'(tbl[i].e_id));
      check($sformatf("tbl%0d.exp_last", i), 32'(last_grant), 32'(tbl[i].e_last));
    end

    // unacknowledged grant: pointer is at 2, so request 8'h06 wraps to client 1
`ifdef ARB_GNT_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      step(8'h06, 8'h00, 0, $sformatf("to_hold%0d", i));
      check($sformatf("to_hold%0d.grant", i), 32'(grant), 32'h02);
      check($sformatf("to_hold%0d.pulse", i), 32'(timeout_pulse), 32'd0);
    end
    step(8'h06, 8'h00, 0, "to_revoke");
    check("to_revoke.grant", 32'(grant), 32'h04);
    check("to_revoke.pulse", 32'(timeout_pulse), 32'd1);
    step(8'h06, 8'h00, 0, "to_after");
    check("to_after.grant", 32'(grant), 32'h04);
    check("to_after.pulse", 32'(timeout_pulse), 32'd0);
`else
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      step(8'h06, 8'h00, 0, $sformatf("hold%0d", i));
      check($sformatf("hold%0d.grant", i), 32'(grant), 32'h02);
    end
    step(8'h06, 8'h02, 0, "hold_ack");
    check("hold_ack.grant", 32'(grant), 32'h04);
`endif
    step(8'h00, 8'h00, 0, "drain");
    check("drain.valid", 32'(grant_valid), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, a;
      logic b;
      r = N'($urandom) | N'($urandom);
      a = ($urandom_range(0, 2) == 0) ? '0 : (N'($urandom) & N'($urandom));
      b = ($urandom_range(0, 7) == 0);
      step(r, a, b, $sformatf("rnd%0d", i));
    end

    // asynchronous reset in the middle of a grant
    step(8'hFF, 8'h00, 0, "pre_rst0");
    step(8'hFF, 8'h00, 0, "pre_rst1");
    check("pre_rst.valid", 32'(grant_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("async_rst.valid", 32'(grant_valid), 32'd0);
    check("async_rst.grant", 32'(grant), 32'd0);
    check("async_rst.grant_id", 32'(grant_id), 32'd0);
    check("async_rst.last_grant", 32'(last_grant), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(8'hFF, 8'h00, 0, "post_rst");
    check("post_rst.grant", 32'(grant), 32'h01);
    check("post_rst.grant_id", 32'(grant_id), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
